am_insert_tx: RTL



---
 rtl/am_insert_tx.sv | 112 +++++++++++
 1 files changed

// File: rtl/am_insert_tx.sv
// am_insert_tx: TX alignment marker inserter for one 40GBASE-R PCS lane.
// Every GAP_N accepted data blocks it takes one output slot, stalls the
// upstream for that cycle and emits the lane marker with BIP3/BIP7 filled in
// from the running parity of everything sent since the previous marker.
module am_insert_tx #(
    parameter int BLOCK_W = 66,
    parameter int LANE_N  = 4,
    parameter int LANE    = 0,
    parameter int GAP_N   = 16383
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               valid_i,
    input  logic [BLOCK_W-1:0] block_i,
    output logic               ready_o,
    output logic               valid_o,
    output logic [BLOCK_W-1:0] block_o,
    output logic               am_v_o
);

    localparam int CNT_W    = $clog2(GAP_N + 1);
    localparam int LANE_SEL = LANE % LANE_N;

    // Marker bytes packed as {M6,M5,M4,M2,M1,M0}; M0 lands in the lowest byte.
    function automatic logic [47:0] lane_marker(input int lane);
        case (lane)
            1:       return {8'h19, 8'h3B, 8'h0F, 8'hE6, 8'hC4, 8'hF0};
            2:       return {8'h64, 8'h9A, 8'h3A, 8'h9B, 8'h65, 8'hC5};
            3:       return {8'hC2, 8'h86, 8'h5D, 8'h3D, 8'h79, 8'hA2};
            default: return {8'hB8, 8'h89, 8'h6F, 8'h47, 8'h76, 8'h90};
        endcase
    endfunction

    localparam logic [47:0] M_BYTES = lane_marker(LANE_SEL);

    // Per-block BIP contribution: column parity of the eight payload bytes,
    // with sync bit 0 folded into bit 3 and sync bit 1 into bit 4.
    function automatic logic [7:0] blk_bip(input logic [BLOCK_W-1:0] b);
        logic [7:0] p;
        p = '0;
        for (int j = 0; j < 8; j++) begin
            p = p ^ b[2 + 8*j +: 8];
        end
        p[3] = p[3] ^ b[0];
        p[4] = p[4] ^ b[1];
        return p;
    endfunction

    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [7:0]         bip_acc, bip_nxt;
    logic               am_pending, pend_nxt;
    logic               valid_nxt, am_v_nxt;
    logic [BLOCK_W-1:0] block_nxt;
    logic [BLOCK_W-1:0] marker;

    // Marker assembled from the accumulated parity; BIP7 is the complement.
    always_comb begin
        marker = {~bip_acc, M_BYTES[47:24], bip_acc, M_BYTES[23:0], 2'b10};
    end

    // Upstream stalls exactly during the marker slot; no path from valid_i.
    assign ready_o = ~am_pending;

    // Next-state: marker slot wins, otherwise pass accepted data through.
    always_comb begin
        valid_nxt = 1'b0;
        am_v_nxt  = 1'b0;
        block_nxt = block_o;
        cnt_nxt   = cnt;
        bip_nxt   = bip_acc;
        pend_nxt  = am_pending;
        if (am_pending) begin
            // Marker goes out whether or not upstream has a block waiting;
            // the parity restarts from the marker as actually sent.
            valid_nxt = 1'b1;
            am_v_nxt  = 1'b1;
            block_nxt = marker;
            cnt_nxt   = '0;
            bip_nxt   = blk_bip(marker);
            pend_nxt  = 1'b0;
        end else if (valid_i) begin
            valid_nxt = 1'b1;
            block_nxt = block_i;
            cnt_nxt   = cnt + CNT_W'(1);
            bip_nxt   = bip_acc ^ blk_bip(block_i);
            // The GAP_N-th data block arms the marker for the very next slot.
            if (cnt == CNT_W'(GAP_N - 1)) begin
                pend_nxt = 1'b1;
            end
        end
    end

    // State and output registers; reset arms a marker as the first block.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_o    <= 1'b0;
            am_v_o     <= 1'b0;
            block_o    <= '0;
            cnt        <= '0;
            bip_acc    <= '0;
            am_pending <= 1'b1;
        end else begin
            valid_o    <= valid_nxt;
            am_v_o     <= am_v_nxt;
            block_o    <= block_nxt;
            cnt        <= cnt_nxt;
            bip_acc    <= bip_nxt;
            am_pending <= pend_nxt;
        end
    end

endmodule
